// File: rtl/da_mem_pkg.sv
// Shared types and constants for the memory handshake checker.
// Optional feature macro: DA_MEM_ASSERT_EN (see da_mem_chan_monitor).
package da_mem_pkg;

    // Per-channel handshake state
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

    // Error flag indices inside a channel's flag vector
    localparam int unsigned NERR       = 4;
    localparam int unsigned ERR_STABLE = 0;
    localparam int unsigned ERR_DROP   = 1;
    localparam int unsigned ERR_SPUR   = 2;
    localparam int unsigned ERR_TMO    = 3;

    // Default channel geometry; the top parameters start from these
    localparam int unsigned DEF_NCH      = 2;
    localparam int unsigned DEF_ADDR_W   = 64;
    localparam int unsigned DEF_DATA_W   = 64;
    localparam int unsigned DEF_STRB_W   = 8;
    localparam int unsigned DEF_PRV_W    = 2;
    localparam int unsigned DEF_MAX_WAIT = 16;
    localparam int unsigned DEF_CNT_W    = 32;

    // Request payload at the default geometry. The monitor declares a
    // matching layout sized by the parameters the top hands down.
    typedef struct packed {
        logic                  wen;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_STRB_W-1:0] strb;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_PRV_W-1:0]  prv;
    } mem_req_t;

    // Width of a counter that must hold 0..max_wait inclusive
    function automatic int unsigned wait_width(input int unsigned max_wait);
        return (max_wait < 1) ? 1 : int'($clog2(max_wait + 1));
    endfunction

endpackage

// File: rtl/da_mem_chan_monitor.sv
// One memory channel's req/gnt protocol monitor: FSM, capture register,
// wait counter, sticky error flags and completed-transaction counter.
// With DA_MEM_ASSERT_EN defined, each flag set condition is also a
// concurrent assertion naming the channel.
module da_mem_chan_monitor
    import da_mem_pkg::*;
#(
    parameter int unsigned CH_IDX   = 0,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned STRB_W   = DEF_STRB_W,
    parameter int unsigned PRV_W    = DEF_PRV_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              g_resetn,
    input  logic              clr_err,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [STRB_W-1:0] mem_strb,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [PRV_W-1:0]  mem_prv,
    input  logic              mem_gnt,
    output logic [NERR-1:0]   err_flags,
    output logic [CNT_W-1:0]  txn_count
);

    localparam int unsigned       WAIT_W   = wait_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdata;
        logic [PRV_W-1:0]  prv;
    } chan_req_t;

    chan_state_e       r_state;
    chan_state_e       w_state_nxt;
    chan_req_t         r_cap;
    chan_req_t         w_cap_nxt;
    chan_req_t         w_cur;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [NERR-1:0]   r_err;
    logic [NERR-1:0]   w_set;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_cnt_inc;
    logic              w_fields_diff;

    // Present request fields gathered into one payload
    always_comb begin
        w_cur       = '0;
        w_cur.wen   = mem_wen;
        w_cur.addr  = mem_addr;
        w_cur.strb  = mem_strb;
        w_cur.wdata = mem_wdata;
        w_cur.prv   = mem_prv;
    end

    // Held request differs from capture; strobe/data only matter for writes
    always_comb begin
        w_fields_diff = (w_cur.wen  != r_cap.wen)  ||
                        (w_cur.addr != r_cap.addr) ||
                        (w_cur.prv  != r_cap.prv)  ||
                        (r_cap.wen && ((w_cur.strb  != r_cap.strb) ||
                                       (w_cur.wdata != r_cap.wdata)));
    end

    // Next state, capture, wait count, flag set pulses and count increment
    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_wait_nxt  = r_wait;
        w_set       = '0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_req && mem_gnt) begin
                    w_cnt_inc = 1'b1;
                end else if (mem_req) begin
                    w_cap_nxt        = w_cur;
                    w_wait_nxt       = WAIT_ONE;
                    w_state_nxt      = WAIT;
                    w_set[ERR_TMO]   = (WAIT_MAX == WAIT_ONE);
                end else if (mem_gnt) begin
                    w_set[ERR_SPUR]  = 1'b1;
                end
            end
            WAIT: begin
                if (!mem_req) begin
                    w_set[ERR_DROP]  = 1'b1;
                    w_set[ERR_SPUR]  = mem_gnt;
                    w_wait_nxt       = '0;
                    w_state_nxt      = IDLE;
                end else begin
                    w_set[ERR_STABLE] = w_fields_diff;
                    if (mem_gnt) begin
                        w_cnt_inc   = 1'b1;
                        w_wait_nxt  = '0;
                        w_state_nxt = IDLE;
                    end else if (r_wait != WAIT_MAX) begin
                        // Saturation at WAIT_MAX keeps the timeout to one pulse
                        w_wait_nxt     = r_wait + WAIT_ONE;
                        w_set[ERR_TMO] = ((r_wait + WAIT_ONE) == WAIT_MAX);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // State, capture and wait counter registers
    always_ff @(posedge clock) begin
        if (!g_resetn) begin
            r_state <= IDLE;
            r_cap   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Sticky flags: a new violation overrides a coincident clear
    always_ff @(posedge clock) begin
        if (!g_resetn) begin
            r_err <= '0;
        end else begin
            r_err <= w_set | (r_err & {NERR{~clr_err}});
        end
    end

    // Completed transaction counter, wraps naturally
    always_ff @(posedge clock) begin
        if (!g_resetn) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign err_flags = r_err;
    assign txn_count = r_cnt;

`ifdef DA_MEM_ASSERT_EN
    a_stable: assert property (@(posedge clock) disable iff (!g_resetn) !w_set[ERR_STABLE])
        else $error("da_mem ch%0d: request fields changed while waiting", CH_IDX);
    a_drop: assert property (@(posedge clock) disable iff (!g_resetn) !w_set[ERR_DROP])
        else $error("da_mem ch%0d: request dropped before grant", CH_IDX);
    a_spur: assert property (@(posedge clock) disable iff (!g_resetn) !w_set[ERR_SPUR])
        else $error("da_mem ch%0d: grant without request", CH_IDX);
    a_tmo: assert property (@(posedge clock) disable iff (!g_resetn) !w_set[ERR_TMO])
        else $error("da_mem ch%0d: request not granted within MAX_WAIT", CH_IDX);
`endif

endmodule

// File: rtl/da_mem_handshake_checker.sv
// Multi-channel req/gnt handshake checker: one monitor per channel,
// per-channel flag/count buses and a registered OR of every flag.
// Optional macro DA_MEM_ASSERT_EN turns flag conditions into assertions.
module da_mem_handshake_checker
    import da_mem_pkg::*;
#(
    parameter int unsigned NCH      = DEF_NCH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned STRB_W   = DEF_STRB_W,
    parameter int unsigned PRV_W    = DEF_PRV_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                  clock,
    input  logic                  g_resetn,
    input  logic                  clr_err,
    input  logic [NCH-1:0]        mem_req,
    input  logic [NCH-1:0]        mem_wen,
    input  logic [NCH*ADDR_W-1:0] mem_addr,
    input  logic [NCH*STRB_W-1:0] mem_strb,
    input  logic [NCH*DATA_W-1:0] mem_wdata,
    input  logic [NCH*PRV_W-1:0]  mem_prv,
    input  logic [NCH-1:0]        mem_gnt,
    output logic [NCH-1:0]        err_stable,
    output logic [NCH-1:0]        err_drop,
    output logic [NCH-1:0]        err_spurious,
    output logic [NCH-1:0]        err_timeout,
    output logic                  any_err,
    output logic [NCH*CNT_W-1:0]  txn_count
);

    logic r_any_err;

    // One independent monitor per channel on its slice of the buses
    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        logic [NERR-1:0] w_flags;

        da_mem_chan_monitor #(
            .CH_IDX   (g),
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .STRB_W   (STRB_W),
            .PRV_W    (PRV_W),
            .MAX_WAIT (MAX_WAIT),
            .CNT_W    (CNT_W)
        ) u_mon (
            .clock     (clock),
            .g_resetn  (g_resetn),
            .clr_err   (clr_err),
            .mem_req   (mem_req[g]),
            .mem_wen   (mem_wen[g]),
            .mem_addr  (mem_addr[g*ADDR_W +: ADDR_W]),
            .mem_strb  (mem_strb[g*STRB_W +: STRB_W]),
            .mem_wdata (mem_wdata[g*DATA_W +: DATA_W]),
            .mem_prv   (mem_prv[g*PRV_W +: PRV_W]),
            .mem_gnt   (mem_gnt[g]),
            .err_flags (w_flags),
            .txn_count (txn_count[g*CNT_W +: CNT_W])
        );

        assign err_stable[g]   = w_flags[ERR_STABLE];
        assign err_drop[g]     = w_flags[ERR_DROP];
        assign err_spurious[g] = w_flags[ERR_SPUR];
        assign err_timeout[g]  = w_flags[ERR_TMO];
    end

    // Summary flag, one cycle behind the per-channel flags
    always_ff @(posedge clock) begin
        if (!g_resetn) begin
            r_any_err <= 1'b0;
        end else begin
            r_any_err <= |{err_stable, err_drop, err_spurious, err_timeout};
        end
    end

    assign any_err = r_any_err;

endmodule

// File: tb/tb_da_mem_handshake_checker.sv
// Bench for da_mem_handshake_checker: directed protocol scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_da_mem_handshake_checker;

    localparam int NCH = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int SW  = 2;
    localparam int PW  = 2;
    localparam int MW  = 4;
    localparam int CW  = 8;

    logic              clock = 1'b0;
    logic              g_resetn;
    logic              clr_err;
    logic [NCH-1:0]    mem_req, mem_wen, mem_gnt;
    logic [NCH*AW-1:0] mem_addr;
    logic [NCH*SW-1:0] mem_strb;
    logic [NCH*DW-1:0] mem_wdata;
    logic [NCH*PW-1:0] mem_prv;
    logic [NCH-1:0]    err_stable, err_drop, err_spurious, err_timeout;
    logic              any_err;
    logic [NCH*CW-1:0] txn_count;

    da_mem_handshake_checker #(
        .NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .PRV_W(PW),
        .MAX_WAIT(MW), .CNT_W(CW)
    ) dut (
        .clock(clock), .g_resetn(g_resetn), .clr_err(clr_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_prv(mem_prv),
        .mem_gnt(mem_gnt), .err_stable(err_stable), .err_drop(err_drop),
        .err_spurious(err_spurious), .err_timeout(err_timeout),
        .any_err(any_err), .txn_count(txn_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: one outstanding-request record per channel plus expected outputs
    logic          m_busy  [NCH];
    logic          m_wen   [NCH];
    logic [AW-1:0] m_addr  [NCH];
    logic [SW-1:0] m_strb  [NCH];
    logic [DW-1:0] m_wdata [NCH];
    logic [PW-1:0] m_prv   [NCH];
    int            m_age   [NCH];
    logic [NCH-1:0] e_stable, e_drop, e_spur, e_tmo;
    logic           e_any;
    logic [CW-1:0]  e_cnt [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_busy[c] = 1'b0; m_age[c] = 0; e_cnt[c] = '0;
        end
        e_stable = '0; e_drop = '0; e_spur = '0; e_tmo = '0; e_any = 1'b0;
    endtask

    // Apply the protocol rules to the inputs present at this clock edge
    task automatic model_step();
        logic [NCH-1:0] s_st, s_dr, s_sp, s_tm;
        logic any_next, same;
        if (!g_resetn) begin
            model_reset();
            return;
        end
        any_next = |{e_stable, e_drop, e_spur, e_tmo};
        s_st = '0; s_dr = '0; s_sp = '0; s_tm = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!m_busy[c]) begin
                if (mem_req[c] && mem_gnt[c]) begin
                    e_cnt[c] = e_cnt[c] + CW'(1);
                end else if (mem_req[c]) begin
                    m_busy[c]  = 1'b1;
                    m_wen[c]   = mem_wen[c];
                    m_addr[c]  = mem_addr[c*AW +: AW];
                    m_strb[c]  = mem_strb[c*SW +: SW];
                    m_wdata[c] = mem_wdata[c*DW +: DW];
                    m_prv[c]   = mem_prv[c*PW +: PW];
                    m_age[c]   = 1;
                    if (m_age[c] == MW) s_tm[c] = 1'b1;
                end else if (mem_gnt[c]) begin
                    s_sp[c] = 1'b1;
                end
            end else if (!mem_req[c]) begin
                s_dr[c]   = 1'b1;
                s_sp[c]   = mem_gnt[c];
                m_busy[c] = 1'b0;
            end else begin
                same = (mem_wen[c] == m_wen[c]) &&
                       (mem_addr[c*AW +: AW] == m_addr[c]) &&
                       (mem_prv[c*PW +: PW] == m_prv[c]) &&
                       (!m_wen[c] || ((mem_strb[c*SW +: SW] == m_strb[c]) &&
                                      (mem_wdata[c*DW +: DW] == m_wdata[c])));
                if (!same) s_st[c] = 1'b1;
                if (mem_gnt[c]) begin
                    e_cnt[c]  = e_cnt[c] + CW'(1);
                    m_busy[c] = 1'b0;
                end else begin
                    m_age[c] = m_age[c] + 1;
                    if (m_age[c] == MW) s_tm[c] = 1'b1;
                end
            end
        end
        e_stable = s_st | (e_stable & ~{NCH{clr_err}});
        e_drop   = s_dr | (e_drop   & ~{NCH{clr_err}});
        e_spur   = s_sp | (e_spur   & ~{NCH{clr_err}});
        e_tmo    = s_tm | (e_tmo    & ~{NCH{clr_err}});
        e_any    = any_next;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("err_stable",   64'(err_stable),   64'(e_stable));
        chk("err_drop",     64'(err_drop),     64'(e_drop));
        chk("err_spurious", 64'(err_spurious), 64'(e_spur));
        chk("err_timeout",  64'(err_timeout),  64'(e_tmo));
        chk("any_err",      64'(any_err),      64'(e_any));
        for (int c = 0; c < NCH; c++)
            chk($sformatf("txn_count[%0d]", c), 64'(txn_count[c*CW +: CW]), 64'(e_cnt[c]));
    endtask

    // One clock: model consumes the same inputs, outputs compared after the edge
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk_all();
    endtask

    task automatic set_req(input int c, input logic req, input logic gnt);
        mem_req[c] = req;
        mem_gnt[c] = gnt;
    endtask

    task automatic set_fields(input int c, input logic wen, input logic [AW-1:0] addr,
                              input logic [SW-1:0] strb, input logic [DW-1:0] wdata,
                              input logic [PW-1:0] prv);
        mem_wen[c]           = wen;
        mem_addr[c*AW +: AW] = addr;
        mem_strb[c*SW +: SW] = strb;
        mem_wdata[c*DW +: DW] = wdata;
        mem_prv[c*PW +: PW]  = prv;
    endtask

    initial begin
        g_resetn = 1'b0; clr_err = 1'b0;
        mem_req = '0; mem_gnt = '0; mem_wen = '0;
        mem_addr = '0; mem_strb = '0; mem_wdata = '0; mem_prv = '0;
        model_reset();
        tick(); tick();
        chk("reset_any", 64'(any_err), 64'(0));
        chk("reset_cnt", 64'(txn_count), 64'(0));
        g_resetn = 1'b1;

        // Three back-to-back single-cycle transactions on ch0
        set_fields(0, 1'b0, 16'h0040, 2'b00, 16'h0000, 2'd3);
        set_req(0, 1'b1, 1'b1);
        repeat (3) tick();
        set_req(0, 1'b0, 1'b0);
        tick();
        chk("t1_cnt0", 64'(txn_count[0 +: CW]), 64'(3));
        chk("t1_cnt1", 64'(txn_count[CW +: CW]), 64'(0));
        chk("t1_flags", 64'({err_stable, err_drop, err_spurious, err_timeout}), 64'(0));

        // Address changes while ch0 waits
        set_fields(0, 1'b0, 16'h1000, 2'b00, 16'h0000, 2'd1);
        set_req(0, 1'b1, 1'b0);
        tick();
        chk("t2_stable_pre", 64'(err_stable[0]), 64'(0));
        set_fields(0, 1'b0, 16'h1008, 2'b00, 16'h0000, 2'd1);
        tick();
        chk("t2_stable", 64'(err_stable[0]), 64'(1));
        tick();
        set_req(0, 1'b1, 1'b1);
        tick();
        set_req(0, 1'b0, 1'b0);
        tick();
        chk("t2_cnt0", 64'(txn_count[0 +: CW]), 64'(4));
        chk("t2_tmo", 64'(err_timeout[0]), 64'(0));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t2_clr", 64'(err_stable[0]), 64'(0));

        // ch1 write request abandoned
        set_fields(1, 1'b1, 16'h2000, 2'b11, 16'hBEEF, 2'd0);
        set_req(1, 1'b1, 1'b0);
        tick(); tick();
        set_req(1, 1'b0, 1'b0);
        tick();
        chk("t3_drop", 64'(err_drop[1]), 64'(1));
        chk("t3_cnt1", 64'(txn_count[CW +: CW]), 64'(0));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t3_clr", 64'(err_drop[1]), 64'(0));

        // Timeout fires once at MAX_WAIT and stays clear after a clear
        set_fields(0, 1'b0, 16'h3000, 2'b00, 16'h0000, 2'd2);
        set_req(0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("t4_tmo_early", 64'(err_timeout[0]), 64'(0));
        tick();
        chk("t4_tmo_set", 64'(err_timeout[0]), 64'(1));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t4_tmo_c5", 64'(err_timeout[0]), 64'(0));
        tick();
        chk("t4_tmo_c6", 64'(err_timeout[0]), 64'(0));
        set_req(0, 1'b1, 1'b1);
        tick();
        chk("t4_tmo_c7", 64'(err_timeout[0]), 64'(0));
        chk("t4_cnt0", 64'(txn_count[0 +: CW]), 64'(5));
        set_req(0, 1'b0, 1'b0);
        tick();

        // Spurious grant coinciding with a clear
        set_req(1, 1'b0, 1'b1);
        clr_err = 1'b1;
        tick();
        chk("t5_spur", 64'(err_spurious[1]), 64'(1));
        set_req(1, 1'b0, 1'b0);
        clr_err = 1'b0;
        tick();
        chk("t5_any", 64'(any_err), 64'(1));

        // Reset while ch0 waits, then a fresh transaction
        set_req(0, 1'b1, 1'b0);
        tick(); tick();
        g_resetn = 1'b0;
        tick();
        chk("t6_rst_flags", 64'({err_stable, err_drop, err_spurious, err_timeout, any_err}), 64'(0));
        chk("t6_rst_cnt", 64'(txn_count), 64'(0));
        g_resetn = 1'b1;
        set_req(0, 1'b1, 1'b1);
        tick();
        chk("t6_cnt0", 64'(txn_count[0 +: CW]), 64'(1));
        chk("t6_flags", 64'({err_stable, err_drop, err_spurious, err_timeout}), 64'(0));

        // Counter wraps modulo 2^CNT_W
        repeat (255) tick();
        chk("wrap_cnt0", 64'(txn_count[0 +: CW]), 64'(0));
        set_req(0, 1'b0, 1'b0);
        tick();

        // Randomized traffic on both channels
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 4))
                        0: mem_wen[c] = ~mem_wen[c];
                        1: mem_addr[c*AW +: AW] = AW'($urandom_range(0, 3) << 2);
                        2: mem_strb[c*SW +: SW] = SW'($urandom);
                        3: mem_wdata[c*DW +: DW] = DW'($urandom);
                        default: mem_prv[c*PW +: PW] = PW'($urandom);
                    endcase
                end
                if (m_busy[c]) mem_req[c] = ($urandom_range(0, 9) != 0);
                else           mem_req[c] = ($urandom_range(0, 9) < 4);
                mem_gnt[c] = ($urandom_range(0, 9) < 3);
            end
            clr_err  = ($urandom_range(0, 24) == 0);
            g_resetn = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
